// File: rtl/toggle_point_gen.sv
// rtl/toggle_point_gen.sv - per-bit toggle coverage tracker with one-shot/every-transition reporting
module toggle_point_gen #(
    parameter int WIDTH      = 6,
    parameter int FIRST_ONLY = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic [WIDTH-1:0] probe,
    output logic [WIDTH-1:0] valid,
    output logic [WIDTH-1:0] covered,
    output logic [15:0]      hit_count,
    output logic             all_covered
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ARMED = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam int PW = $clog2(WIDTH + 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] rise_seen;
    logic [WIDTH-1:0] fall_seen;

    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] rise_nxt;
    logic [WIDTH-1:0] fall_nxt;
    logic [WIDTH-1:0] cov_nxt;
    logic [WIDTH-1:0] valid_nxt;
    logic [PW-1:0]    pop;
    logic [16:0]      sum;
    logic [15:0]      hit_nxt;

    // Edge detection against the last enabled sample and the candidate next coverage/report values
    always_comb begin
        rise     = ~prev & probe;
        fall     = prev & ~probe;
        rise_nxt = rise_seen | rise;
        fall_nxt = fall_seen | fall;
        cov_nxt  = covered | (rise_nxt & fall_nxt);
        if (FIRST_ONLY != 0) begin
            valid_nxt = rise_nxt & fall_nxt & ~covered;
        end else begin
            valid_nxt = rise | fall;
        end
        pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop = pop + PW'(valid_nxt[i]);
        end
        // Pop count is far below 2^16, so a carry out means the counter crossed 65535
        sum     = {1'b0, hit_count} + 17'(pop);
        hit_nxt = sum[16] ? 16'hFFFF : sum[15:0];
    end

    // Sampling state machine; clear outranks enable, and valid is a single-cycle pulse by default
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            prev        <= '0;
            rise_seen   <= '0;
            fall_seen   <= '0;
            covered     <= '0;
            valid       <= '0;
            hit_count   <= '0;
            all_covered <= 1'b0;
        end else begin
            valid       <= '0;
            all_covered <= &covered;
            if (clear) begin
                state       <= IDLE;
                rise_seen   <= '0;
                fall_seen   <= '0;
                covered     <= '0;
                hit_count   <= '0;
                all_covered <= 1'b0;
            end else if (enable) begin
                case (state)
                    IDLE: begin
                        prev  <= probe;
                        state <= ARMED;
                    end
                    ARMED: begin
                        prev      <= probe;
                        rise_seen <= rise_nxt;
                        fall_seen <= fall_nxt;
                        covered   <= cov_nxt;
                        valid     <= valid_nxt;
                        hit_count <= hit_nxt;
                        if ((FIRST_ONLY != 0) && (&cov_nxt)) begin
                            state <= DONE;
                        end
                    end
                    default: begin
                        state <= state;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_toggle_point_gen.sv
// tb/tb_toggle_point_gen.sv - self-checking bench for toggle_point_gen
module tb_toggle_point_gen;

    logic        clock;
    logic        reset;
    logic        enable;
    logic        clear;
    logic [5:0]  probe;
    logic [5:0]  valid1, covered1, valid0, covered0;
    logic [15:0] hit1, hit0;
    logic        allcov1, allcov0;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic        en;
        logic        cl;
        logic [5:0]  p;
        logic [5:0]  ev;
        logic [5:0]  ecov;
        logic [15:0] ehit;
        logic        eac;
        logic [5:0]  ev0;
    } vec_t;

    vec_t tbl[27];
    vec_t sb[$];

    toggle_point_gen #(.WIDTH(6), .FIRST_ONLY(1)) dut1 (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear), .probe(probe),
        .valid(valid1), .covered(covered1), .hit_count(hit1), .all_covered(allcov1)
    );

    toggle_point_gen #(.WIDTH(6), .FIRST_ONLY(0)) dut0 (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear), .probe(probe),
        .valid(valid0), .covered(covered0), .hit_count(hit0), .all_covered(allcov0)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic en, input logic cl, input logic [5:0] p,
                                input logic [5:0] ev, input logic [5:0] ecov,
                                input logic [15:0] ehit, input logic eac, input logic [5:0] ev0);
        vec_t v;
        v.en = en; v.cl = cl; v.p = p; v.ev = ev; v.ecov = ecov;
        v.ehit = ehit; v.eac = eac; v.ev0 = ev0;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input int act, input int req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s[%0d] actual=%0h required=%0h", name, idx, act, req);
        end
    endtask

    // Called at a falling edge: drive, queue expectation, sample 1ns after the rising edge
    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        enable = v.en;
        clear  = v.cl;
        probe  = v.p;
        sb.push_back(v);
        @(posedge clock);
        #1;
        e = sb.pop_front();
        chk("valid",       idx, int'(valid1),   int'(e.ev));
        chk("covered",     idx, int'(covered1), int'(e.ecov));
        chk("hit_count",   idx, int'(hit1),     int'(e.ehit));
        chk("all_covered", idx, int'(allcov1),  int'(e.eac));
        chk("valid_every", idx, int'(valid0),   int'(e.ev0));
        @(negedge clock);
    endtask

    initial begin
        //              en    cl    probe  valid  cov    hit  ac    valid(every)
        tbl[0]  = mk(1'b1, 1'b0, 6'h00, 6'h00, 6'h00, 16'd0, 1'b0, 6'h00);
        tbl[1]  = mk(1'b1, 1'b0, 6'h01, 6'h00, 6'h00, 16'd0, 1'b0, 6'h01);
        tbl[2]  = mk(1'b1, 1'b0, 6'h00, 6'h01, 6'h01, 16'd1, 1'b0, 6'h01);
        tbl[3]  = mk(1'b1, 1'b0, 6'h00, 6'h00, 6'h01, 16'd1, 1'b0, 6'h00);
        tbl[4]  = mk(1'b1, 1'b1, 6'h01, 6'h00, 6'h00, 16'd0, 1'b0, 6'h00);
        tbl[5]  = mk(1'b1, 1'b0, 6'h01, 6'h00, 6'h00, 16'd0, 1'b0, 6'h00);
        tbl[6]  = mk(1'b1, 1'b0, 6'h00, 6'h00, 6'h00, 16'd0, 1'b0, 6'h01);
        tbl[7]  = mk(1'b0, 1'b0, 6'h01, 6'h00, 6'h00, 16'd0, 1'b0, 6'h00);
        tbl[8]  = mk(1'b0, 1'b0, 6'h01, 6'h00, 6'h00, 16'd0, 1'b0, 6'h00);
        tbl[9]  = mk(1'b0, 1'b0, 6'h01, 6'h00, 6'h00, 16'd0, 1'b0, 6'h00);
        tbl[10] = mk(1'b0, 1'b0, 6'h01, 6'h00, 6'h00, 16'd0, 1'b0, 6'h00);
        tbl[11] = mk(1'b0, 1'b0, 6'h01, 6'h00, 6'h00, 16'd0, 1'b0, 6'h00);
        tbl[12] = mk(1'b1, 1'b0, 6'h01, 6'h01, 6'h01, 16'd1, 1'b0, 6'h01);
        tbl[13] = mk(1'b1, 1'b0, 6'h3F, 6'h00, 6'h01, 16'd1, 1'b0, 6'h3E);
        tbl[14] = mk(1'b1, 1'b0, 6'h00, 6'h3E, 6'h3F, 16'd6, 1'b0, 6'h3F);
        tbl[15] = mk(1'b1, 1'b0, 6'h3F, 6'h00, 6'h3F, 16'd6, 1'b1, 6'h3F);
        tbl[16] = mk(1'b1, 1'b0, 6'h00, 6'h00, 6'h3F, 16'd6, 1'b1, 6'h3F);
        tbl[17] = mk(1'b1, 1'b1, 6'h00, 6'h00, 6'h00, 16'd0, 1'b0, 6'h00);
        tbl[18] = mk(1'b1, 1'b0, 6'h3F, 6'h00, 6'h00, 16'd0, 1'b0, 6'h00);
        tbl[19] = mk(1'b1, 1'b0, 6'h00, 6'h00, 6'h00, 16'd0, 1'b0, 6'h3F);
        tbl[20] = mk(1'b1, 1'b0, 6'h3F, 6'h3F, 6'h3F, 16'd6, 1'b0, 6'h3F);
        tbl[21] = mk(1'b1, 1'b0, 6'h00, 6'h00, 6'h3F, 16'd6, 1'b1, 6'h3F);
        tbl[22] = mk(1'b0, 1'b1, 6'h00, 6'h00, 6'h00, 16'd0, 1'b0, 6'h00);
        tbl[23] = mk(1'b1, 1'b0, 6'h00, 6'h00, 6'h00, 16'd0, 1'b0, 6'h00);
        tbl[24] = mk(1'b1, 1'b0, 6'h3F, 6'h00, 6'h00, 16'd0, 1'b0, 6'h3F);
        tbl[25] = mk(1'b1, 1'b0, 6'h00, 6'h3F, 6'h3F, 16'd6, 1'b0, 6'h3F);
        tbl[26] = mk(1'b1, 1'b0, 6'h3F, 6'h00, 6'h3F, 16'd6, 1'b1, 6'h3F);

        reset  = 1'b0;
        enable = 1'b0;
        clear  = 1'b0;
        probe  = 6'h00;
        repeat (3) @(negedge clock);
        chk("rst_valid",   0, int'(valid1),   0);
        chk("rst_covered", 0, int'(covered1), 0);
        chk("rst_hit",     0, int'(hit1),     0);
        chk("rst_allcov",  0, int'(allcov1),  0);
        reset = 1'b1;

        for (int i = 0; i < 27; i++) apply(tbl[i], i);

        // Reset asserted while valid is high must drop it without a clock edge
        apply(mk(1'b1, 1'b1, 6'h00, 6'h00, 6'h00, 16'd0, 1'b0, 6'h00), 100);
        apply(mk(1'b1, 1'b0, 6'h00, 6'h00, 6'h00, 16'd0, 1'b0, 6'h00), 101);
        apply(mk(1'b1, 1'b0, 6'h3F, 6'h00, 6'h00, 16'd0, 1'b0, 6'h3F), 102);
        enable = 1'b1;
        probe  = 6'h00;
        @(posedge clock);
        #1;
        chk("pre_rst_valid", 103, int'(valid1), 6'h3F);
        reset = 1'b0;
        #1;
        chk("async_valid",   103, int'(valid1),   0);
        chk("async_valid0",  103, int'(valid0),   0);
        chk("async_covered", 103, int'(covered1), 0);
        chk("async_hit",     103, int'(hit1),     0);
        @(negedge clock);
        reset = 1'b1;
        apply(mk(1'b1, 1'b0, 6'h3F, 6'h00, 6'h00, 16'd0, 1'b0, 6'h00), 104);
        apply(mk(1'b1, 1'b0, 6'h00, 6'h00, 6'h00, 16'd0, 1'b0, 6'h3F), 105);
        apply(mk(1'b1, 1'b0, 6'h3F, 6'h3F, 6'h3F, 16'd6, 1'b0, 6'h3F), 106);

        // Every-transition mode: alternating full toggles saturate the counter
        apply(mk(1'b1, 1'b1, 6'h00, 6'h00, 6'h00, 16'd0, 1'b0, 6'h00), 200);
        for (int i = 0; i < 11000; i++) begin
            enable = 1'b1;
            clear  = 1'b0;
            probe  = i[0] ? 6'h3F : 6'h00;
            @(posedge clock);
            #1;
            if (i == 3) chk("sat_hit_early", i, int'(hit0), 18);
            if (i == 10999) begin
                chk("sat_hit",   i, int'(hit0),   16'hFFFF);
                chk("sat_valid", i, int'(valid0), 6'h3F);
            end
            @(negedge clock);
        end
        probe = 6'h00;
        @(posedge clock);
        #1;
        chk("sat_hold", 11000, int'(hit0), 16'hFFFF);
        @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
